// File: rtl/add32_pkg.sv
// Shared constants for the 32-bit lookahead adder: default width, group
// size of the first-level lookahead, and bit positions inside Flags_q.
package add32_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CLA_GROUP_W   = 4;
  localparam int FLAG_W        = 5;

  // Flag bit positions, MSB first: {C32, Add_Carry, Zero, Add_Overflow, Add_Sign}
  localparam int FLAG_C32   = 4;
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_SIGN  = 0;

endpackage

// File: rtl/add32_cla4.sv
// 4-bit carry-lookahead block. Every internal carry is computed directly
// from the bit propagate/generate terms and cin, so no carry ripples
// inside the group. Group propagate/generate feed the second-level
// lookahead in the parent.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       P,
  output logic       G
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

  assign P = &p;
  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/add32.sv
// 32-bit two-level carry-lookahead adder with combinational sum and flags
// and a one-cycle-delayed flag register. The sum path never touches the
// clock or reset so parents can use S in the same cycle.
module add32
  import add32_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              c0,
  output logic [WIDTH-1:0]  S,
  output logic              C32,
  output logic              Add_Carry,
  output logic              Zero,
  output logic              Add_Overflow,
  output logic              Add_Sign,
  output logic [FLAG_W-1:0] Flags_q
);

  localparam int NUM_GROUPS = WIDTH / CLA_GROUP_W;

  logic [NUM_GROUPS-1:0] grp_p;
  logic [NUM_GROUPS-1:0] grp_g;
  logic [NUM_GROUPS:0]   grp_c;

  // First level: one lookahead block per 4-bit slice
  for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_cla
    cla4 u_cla4 (
      .a   (A[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .b   (B[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .cin (grp_c[gi]),
      .s   (S[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .P   (grp_p[gi]),
      .G   (grp_g[gi])
    );
  end

  // Second level: each group carry-in is a flat sum of products of group
  // generates, group propagates and c0, so no carry waits on another group
  always_comb begin
    logic term;
    term     = 1'b0;
    grp_c    = '0;
    grp_c[0] = c0;
    for (int k = 1; k <= NUM_GROUPS; k++) begin
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        grp_c[k] = grp_c[k] | term;
      end
      term = c0;
      for (int m = 0; m < k; m++) begin
        term = term & grp_p[m];
      end
      grp_c[k] = grp_c[k] | term;
    end
  end

  assign C32          = grp_c[NUM_GROUPS];
  assign Add_Carry    = C32;
  assign Zero         = (S == '0);
  assign Add_Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);
  assign Add_Sign     = S[WIDTH-1];

  // Capture the current flags every edge; reset clears them for that edge only
  always_ff @(posedge clk) begin
    if (rst) begin
      Flags_q <= '0;
    end else begin
      Flags_q[FLAG_C32]   <= C32;
      Flags_q[FLAG_CARRY] <= Add_Carry;
      Flags_q[FLAG_ZERO]  <= Zero;
      Flags_q[FLAG_OVF]   <= Add_Overflow;
      Flags_q[FLAG_SIGN]  <= Add_Sign;
    end
  end

endmodule

// File: tb/tb_add32.sv
// Self-checking bench for add32: directed literal cases, a reset sequence,
// then 10k random operands checked every cycle against a 33-bit
// arithmetic model of the sum and flags.
module tb_add32;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        c0;
  logic [31:0] S;
  logic        C32;
  logic        Add_Carry;
  logic        Zero;
  logic        Add_Overflow;
  logic        Add_Sign;
  logic [4:0]  Flags_q;

  int compared;
  int mismatched;
  bit checking;
  bit fq_valid;
  logic [4:0] exp_fq;

  add32 #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .A            (A),
    .B            (B),
    .c0           (c0),
    .S            (S),
    .C32          (C32),
    .Add_Carry    (Add_Carry),
    .Zero         (Zero),
    .Add_Overflow (Add_Overflow),
    .Add_Sign     (Add_Sign),
    .Flags_q      (Flags_q)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain 33-bit addition, flags from their definitions
  function automatic logic [32:0] model_sum(input logic [31:0] a, input logic [31:0] b,
                                            input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  function automatic logic [4:0] model_flags(input logic [31:0] a, input logic [31:0] b,
                                             input logic c);
    logic [32:0] full;
    logic [31:0] s;
    full = model_sum(a, b, c);
    s    = full[31:0];
    return {full[32], full[32], (s == 32'd0),
            (a[31] == b[31]) && (s[31] != a[31]), s[31]};
  endfunction

  task automatic checkOutput(input string name, input logic [32:0] actual,
                             input logic [32:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (A=%h B=%h c0=%b rst=%b) t=%0t",
               name, actual, expected, A, B, c0, rst, $time);
    end
  endtask

  // Drive new inputs just after a rising edge so the next edge samples them
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic c, input logic r);
    @(posedge clk);
    #1;
    A   = a;
    B   = b;
    c0  = c;
    rst = r;
  endtask

  // Expected register contents, tracked at the rising edge from the inputs
  always @(posedge clk) begin
    exp_fq   <= rst ? 5'b00000 : model_flags(A, B, c0);
    fq_valid <= 1'b1;
  end

  // Every falling edge: combinational outputs and Flags_q against the model
  always @(negedge clk) begin
    if (checking) begin
      logic [32:0] full;
      logic [4:0]  mf;
      full = model_sum(A, B, c0);
      mf   = model_flags(A, B, c0);
      checkOutput("model_S",   {1'b0, S}, {1'b0, full[31:0]});
      checkOutput("model_flags",
                  {28'd0, C32, Add_Carry, Zero, Add_Overflow, Add_Sign}, {28'd0, mf});
      if (fq_valid) checkOutput("model_Flags_q", {28'd0, Flags_q}, {28'd0, exp_fq});
    end
  end

  task automatic checkLiteral(input string name, input logic [31:0] exp_s,
                              input logic [4:0] exp_flags);
    @(negedge clk);
    checkOutput({name, "_S"}, {1'b0, S}, {1'b0, exp_s});
    checkOutput({name, "_flags"},
                {28'd0, C32, Add_Carry, Zero, Add_Overflow, Add_Sign}, {28'd0, exp_flags});
  endtask

  task automatic checkFlagsQ(input string name, input logic [4:0] expected);
    @(negedge clk);
    checkOutput(name, {28'd0, Flags_q}, {28'd0, expected});
  endtask

  // Directed cases, reset sequence, then randomized operands
  initial begin
    compared   = 0;
    mismatched = 0;
    fq_valid   = 1'b0;
    exp_fq     = 5'b00000;
    checking   = 1'b1;
    rst = 1'b1;
    A   = 32'd0;
    B   = 32'd4;
    c0  = 1'b0;

    applyStimulus(32'd0, 32'd4, 1'b0, 1'b0);
    checkFlagsQ("reset_Flags_q", 5'b00000);
    checkLiteral("zero_plus_4", 32'h0000_0004, 5'b00000);

    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    checkFlagsQ("after_0p4_Flags_q", 5'b00000);
    checkLiteral("wrap", 32'h0000_0000, 5'b11100);

    applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    checkLiteral("pos_ovf", 32'h8000_0000, 5'b00011);

    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    checkFlagsQ("pos_ovf_Flags_q", 5'b00011);
    checkLiteral("neg_ovf", 32'h0000_0000, 5'b11110);

    applyStimulus(32'h0000_0010, 32'hFFFF_FFF8, 1'b0, 1'b0);
    checkLiteral("branch", 32'h0000_0008, 5'b11000);

    applyStimulus(32'd5, 32'd6, 1'b1, 1'b0);
    checkLiteral("carry_in", 32'd12, 5'b00000);

    // Reset overrides capture for one edge only
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    checkFlagsQ("rst_seq_before", 5'b11100);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    checkFlagsQ("rst_seq_cleared", 5'b00000);
    checkLiteral("rst_seq_S", 32'h0000_0000, 5'b11100);
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    checkFlagsQ("rst_seq_resumed", 5'b11100);

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ~ra;
        1: rb = -ra;
        2: ra = 32'h7FFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end

    @(negedge clk);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/add32.md
ADD32 -- requirements
Module: add32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width; only 32 is required to be supported.
REQ-002 SHALL have port clk, input, 1, single clock; rising edge active.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port A, input, 32, first operand.
REQ-005 SHALL have port B, input, 32, second operand.
REQ-006 SHALL have port c0, input, 1, carry-in; parents not using it tie it to 0.
REQ-007 SHALL have port S, output, 32, sum.
REQ-008 SHALL have port C32, output, 1, carry out of bit 31.
REQ-009 SHALL have port Add_Carry, output, 1, unsigned-carry flag.
REQ-010 SHALL have port Zero, output, 1, result-zero flag.
REQ-011 SHALL have port Add_Overflow, output, 1, signed-overflow flag.
REQ-012 SHALL have port Add_Sign, output, 1, result sign flag.
REQ-013 SHALL have port Flags_q, output, 5, registered flags {C32, Add_Carry, Zero, Add_Overflow, Add_Sign}.

Function
REQ-014 S and C32 SHALL be purely combinational, {C32,S} = A + B + c0 modulo 2^33, zero cycles of latency, so a parent can use S in the same cycle (e.g. PC+4, branch target).
REQ-015 Add_Carry SHALL equal C32.
REQ-016 Zero SHALL be 1 iff S == 0, regardless of C32.
REQ-017 Add_Overflow SHALL be 1 iff A[31] == B[31] and S[31] != A[31].
REQ-018 Add_Sign SHALL equal S[31].
REQ-019 All combinational outputs SHALL depend only on A, B, c0, never on clk or rst.
REQ-020 Wrap-around: the sum SHALL truncate to 32 bits with the carry reported on C32, and no saturation.
REQ-021 On each rising clk edge with rst low, Flags_q SHALL capture the current combinational flag values, so Flags_q lags the inputs by exactly one cycle.
REQ-022 The adder SHALL be carry-lookahead: 4-bit groups with group propagate/generate, plus a second-level lookahead across the 8 groups; a ripple carry chain across all 32 bits is not permitted.

Reset
REQ-023 With rst high at a rising clk edge, Flags_q SHALL become 5'b00000.
REQ-024 rst SHALL have no effect on S, C32, or the combinational flags.
REQ-025 Reset asserted mid-operation SHALL override capture for that edge only; capture resumes on the first edge with rst low.

Structure
REQ-026 A shared package SHALL hold WIDTH_DEFAULT=32 and the flag bit indices (FLAG_C32=4 … FLAG_SIGN=0).
REQ-027 One sub-module, cla4, SHALL be used: a 4-bit lookahead block with inputs a, b, cin and outputs s, P, G, instantiated 8 times.
REQ-028 The top level SHALL contain the second-level lookahead, the flag logic, and the Flags_q register only.

Verification
REQ-029 A=0, B=4, c0=0 -> S=0x00000004, all flags 0; on the next edge Flags_q=0.
REQ-030 A=0xFFFFFFFF, B=1, c0=0 -> S=0, C32=Add_Carry=1, Zero=1, Add_Overflow=0, Add_Sign=0.
REQ-031 A=0x7FFFFFFF, B=1 -> S=0x80000000, Add_Overflow=1, Add_Sign=1, C32=0; A=0x80000000, B=0x80000000 -> S=0, C32=1, Zero=1, Add_Overflow=1.
REQ-032 Branch case: A=0x00000010, B=0xFFFFFFF8 (sext of -8), c0=0 -> S=0x00000008, C32=1, Add_Overflow=0; carry-in case: A=5, B=6, c0=1 -> S=12.
REQ-033 Reset: drive A=0xFFFFFFFF, B=1 and clock once -> Flags_q=5'b11100; assert rst for one edge -> Flags_q=0 while S stays 0; deassert rst -> next edge Flags_q=5'b11100.
REQ-034 Random check: 10k random A, B, c0 compared against a 33-bit behavioural sum and the flag equations of REQ-015 through REQ-018.
